// File: rtl/mips_step_ctrl.sv
// Execution controller for the single-cycle MIPS board build.
// Debounces the step / run-stop / count-clear buttons and issues one-cycle
// CPU clock-enable pulses in single-step, free-run and breakpoint-halt modes,
// while counting the enable pulses for the display selector.
module mips_step_ctrl #(
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned RUN_DIV   = 5000000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       btn_n,
  input  logic             bp_en,
  input  logic [7:0]       bp_addr,
  input  logic [31:0]      pc,
  output logic             cpu_en,
  output logic             run_mode,
  output logic             halted_bp,
  output logic [CNT_W-1:0] step_count,
  output logic [2:0]       btn_pulse
);

  localparam int unsigned DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned DIV_W = $clog2(RUN_DIV);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, BREAK} state_t;

  // ---------------------------------------------------------------- input path
  logic [2:0]            sync1, sync2;
  logic [2:0]            db_state;
  logic [2:0][DB_W-1:0]  db_cnt;

  // Two-stage synchronizer; idles at the released level so reset never
  // looks like a press.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // Per-button debounce: accept a new level after DB_CYCLES consecutive
  // differing samples; a 1->0 acceptance emits a one-cycle press pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      db_state  <= '1;
      db_cnt    <= '0;
      btn_pulse <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        btn_pulse[i] <= 1'b0;
        if (sync2[i] == db_state[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]    <= '0;
          db_state[i]  <= sync2[i];
          btn_pulse[i] <= ~sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------- control
  logic step_p, run_p, clr_p;
  assign step_p = btn_pulse[0];
  assign run_p  = btn_pulse[1];
  assign clr_p  = btn_pulse[2];

  state_t           state, state_nx;
  logic [DIV_W-1:0] div, div_nx;
  logic             skip_bp, skip_nx;
  logic             en_nx;
  logic             div_tc, bp_hit;

  assign div_tc = (div == DIV_LAST);
  assign bp_hit = bp_en && (pc[9:2] == bp_addr) && !skip_bp;

  // Only pc[9:2] participates in the breakpoint compare.
  logic unused_pc;
  assign unused_pc = ^{pc[31:10], pc[1:0]};

  // State and registered outputs; run_mode/halted_bp follow the next state
  // so they are flop outputs that always equal the current state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      div        <= '0;
      skip_bp    <= 1'b0;
      cpu_en     <= 1'b0;
      run_mode   <= 1'b0;
      halted_bp  <= 1'b0;
      step_count <= '0;
    end else begin
      state     <= state_nx;
      div       <= div_nx;
      skip_bp   <= skip_nx;
      cpu_en    <= en_nx;
      run_mode  <= (state_nx == RUN);
      halted_bp <= (state_nx == BREAK);
      if (clr_p)
        step_count <= '0;
      else if (cpu_en)
        step_count <= step_count + CNT_W'(1);
    end
  end

  // Next-state selection; run/stop always takes priority over step.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (run_p) state_nx = RUN;
      RUN: begin
        if (run_p)
          state_nx = IDLE;
        else if (div_tc && bp_hit)
          state_nx = BREAK;
      end
      BREAK:   if (run_p) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // Enable pulse, rate divider and breakpoint-skip control.
  always_comb begin
    en_nx   = 1'b0;
    skip_nx = skip_bp;
    div_nx  = '0;
    unique case (state)
      IDLE: en_nx = step_p && !run_p;
      RUN: begin
        if (!run_p) begin
          div_nx = div_tc ? '0 : div + DIV_W'(1);
          if (div_tc && !bp_hit) begin
            en_nx   = 1'b1;
            skip_nx = 1'b0;
          end
        end
      end
      BREAK: begin
        en_nx = step_p && !run_p;
        if (run_p) skip_nx = 1'b1;
      end
      default: en_nx = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mips_step_ctrl.sv
`timescale 1ns/1ps
module tb_mips_step_ctrl;

  localparam int unsigned DB  = 4;
  localparam int unsigned DIV = 8;
  localparam int unsigned CW  = 8;   // narrow counter keeps the wrap test short

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [2:0]    btn_n = '1;
  logic          bp_en = 1'b0;
  logic [7:0]    bp_addr = '0;
  logic [31:0]   pc_val = '0;
  logic          pc_clr = 1'b1;
  logic          cpu_en, run_mode, halted_bp;
  logic [CW-1:0] step_count;
  logic [2:0]    btn_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  mips_step_ctrl #(.DB_CYCLES(DB), .RUN_DIV(DIV), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .btn_n(btn_n), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc(pc_val), .cpu_en(cpu_en), .run_mode(run_mode), .halted_bp(halted_bp),
    .step_count(step_count), .btn_pulse(btn_pulse)
  );

  always #5 CLK = ~CLK;

  // CPU stand-in: PC advances one word per committed instruction.
  always @(posedge CLK) begin
    if (pc_clr) pc_val <= '0;
    else if (cpu_en) pc_val <= pc_val + 32'd4;
  end

  // Activity monitors.
  int   en_total = 0;
  int   en_back2back = 0;
  logic en_prev = 1'b0;
  int   pulse_total [3] = '{0, 0, 0};
  always @(posedge CLK) begin
    if (cpu_en) en_total <= en_total + 1;
    if (cpu_en && en_prev) en_back2back <= en_back2back + 1;
    en_prev <= cpu_en;
    for (int i = 0; i < 3; i++)
      if (btn_pulse[i]) pulse_total[i] <= pulse_total[i] + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    btn_n = '1; bp_en = 1'b0; bp_addr = '0; pc_clr = 1'b1;
    #2 RST = 1'b1;
    tick(); tick();
    RST = 1'b0; pc_clr = 1'b0;
  endtask

  task automatic press(input logic [2:0] mask, input int unsigned low_len, input int unsigned high_len);
    btn_n = btn_n & ~mask;
    repeat (low_len) tick();
    btn_n = btn_n | mask;
    repeat (high_len) tick();
  endtask

  // what: 0..2 = btn_pulse bit, 3 = cpu_en, 4 = halted_bp, 5 = step_count all-ones
  task automatic wait_for(input int unsigned what, input int unsigned lim, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < lim; i++) begin
      tick();
      if ((what < 3 && btn_pulse[what]) || (what == 3 && cpu_en) ||
          (what == 4 && halted_bp) || (what == 5 && step_count == '1)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    int unsigned btn;
    int unsigned low_len;
    int unsigned exp_pulses;
    int unsigned exp_count;
  } vec_t;

  // Randomized run against a cycle-timed behavioural model.
  task automatic random_test(input int unsigned ncyc);
    logic [2:0]  hist [$];
    logic [2:0]  db, m_pulse, nx_pulse;
    int unsigned mode, mode_n, m_cnt, nx_cnt;
    bit          m_en, nx_en, skip, all_diff;
    int          due;
    int unsigned hold [3];
    do_reset();
    for (int unsigned k = 0; k < DB + 2; k++) hist.push_back(3'b111);
    db = 3'b111; m_pulse = '0; mode = 0; m_cnt = 0; m_en = 1'b0; skip = 1'b0; due = 0;
    for (int b = 0; b < 3; b++) hold[b] = 10;
    for (int c = 0; c < int'(ncyc); c++) begin
      check($sformatf("rand c%0d cpu_en", c), 32'(cpu_en), 32'(m_en));
      check($sformatf("rand c%0d run_mode", c), 32'(run_mode), 32'(mode == 1));
      check($sformatf("rand c%0d halted_bp", c), 32'(halted_bp), 32'(mode == 2));
      check($sformatf("rand c%0d step_count", c), 32'(step_count), m_cnt);
      check($sformatf("rand c%0d btn_pulse", c), 32'(btn_pulse), 32'(m_pulse));
      // stimulus for this cycle
      for (int b = 0; b < 3; b++) begin
        if (hold[b] == 0) begin
          btn_n[b] = ~btn_n[b];
          if (btn_n[b] == 1'b0)
            hold[b] = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2) : $urandom_range(3, 20);
          else if (b == 0)
            hold[b] = $urandom_range(3, 60);
          else if (b == 1)
            hold[b] = $urandom_range(40, 300);
          else
            hold[b] = $urandom_range(200, 800);
        end else begin
          hold[b]--;
        end
      end
      if ($urandom_range(0, 199) == 0) bp_en = ~bp_en;
      if ($urandom_range(0, 49) == 0) bp_addr = pc_val[9:2] + 8'($urandom_range(0, 4));
      // debounced level changes once DB consecutive synced samples disagree
      hist.push_back(btn_n);
      nx_pulse = '0;
      for (int b = 0; b < 3; b++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= int'(DB); k++)
          if (hist[k][b] == db[b]) all_diff = 1'b0;
        if (all_diff) begin
          db[b] = ~db[b];
          nx_pulse[b] = ~db[b];
        end
      end
      void'(hist.pop_front());
      // controller behaviour
      nx_en  = 1'b0;
      mode_n = mode;
      nx_cnt = m_pulse[2] ? 0 : (m_cnt + 32'(m_en)) % (1 << CW);
      if (mode == 1) begin
        if (m_pulse[1]) mode_n = 0;
        else if (c == due) begin
          due = due + int'(DIV);
          if (bp_en && pc_val[9:2] == bp_addr && !skip) mode_n = 2;
          else begin nx_en = 1'b1; skip = 1'b0; end
        end
      end else begin
        if (m_pulse[1]) begin
          mode_n = 1;
          due = c + int'(DIV);
          if (mode == 2) skip = 1'b1;
        end else if (m_pulse[0]) begin
          nx_en = 1'b1;
        end
      end
      m_en = nx_en; m_pulse = nx_pulse; m_cnt = nx_cnt; mode = mode_n;
      tick();
    end
  endtask

  initial begin
    vec_t        vecs [8];
    int          e0, p0, lat, npulse, bad;
    int          times [$];
    bit          ok;
    logic [31:0] pc_seen;

    // ---- reset state
    tick(); tick();
    check("reset cpu_en", 32'(cpu_en), 0);
    check("reset run_mode", 32'(run_mode), 0);
    check("reset halted_bp", 32'(halted_bp), 0);
    check("reset step_count", 32'(step_count), 0);
    check("reset btn_pulse", 32'(btn_pulse), 0);

    // ---- table: press lengths vs. accepted pulses, all in IDLE
    vecs[0] = '{0, 1, 0, 0};
    vecs[1] = '{0, 3, 0, 0};
    vecs[2] = '{0, 4, 1, 1};
    vecs[3] = '{0, 10, 1, 2};
    vecs[4] = '{2, 3, 0, 2};
    vecs[5] = '{2, 5, 1, 0};
    vecs[6] = '{0, 7, 1, 1};
    vecs[7] = '{1, 2, 0, 1};
    do_reset();
    foreach (vecs[i]) begin
      p0 = pulse_total[vecs[i].btn];
      press(3'(1 << vecs[i].btn), vecs[i].low_len, 12);
      check($sformatf("vec%0d pulses", i), pulse_total[vecs[i].btn] - p0, vecs[i].exp_pulses);
      check($sformatf("vec%0d step_count", i), 32'(step_count), vecs[i].exp_count);
      check($sformatf("vec%0d run_mode", i), 32'(run_mode), 0);
    end

    // ---- debounce latency with glitches
    do_reset();
    p0 = pulse_total[0];
    press(3'b001, 3, 3);
    press(3'b001, 3, 3);
    check("glitch pulses", pulse_total[0] - p0, 0);
    btn_n[0] = 1'b0;
    lat = 0; npulse = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (btn_pulse[0]) begin npulse++; if (lat == 0) lat = i; end
    end
    btn_n[0] = 1'b1;
    check("debounce latency", lat, 2 + DB);
    check("debounce pulse count", npulse, 1);
    npulse = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (btn_pulse[0]) npulse++; end
    check("release pulse count", npulse, 0);

    // ---- single step
    do_reset();
    e0 = en_total;
    repeat (5) press(3'b001, 6, 10);
    tick(); tick();
    check("step en pulses", en_total - e0, 5);
    check("step step_count", 32'(step_count), 5);
    check("step run_mode", 32'(run_mode), 0);

    // ---- run rate and stop
    do_reset();
    btn_n[1] = 1'b0;
    wait_for(1, 20, ok);
    check("run pulse seen", 32'(ok), 1);
    btn_n[1] = 1'b1;
    for (int i = 1; i <= 72; i++) begin tick(); if (cpu_en) times.push_back(i); end
    check("run pulse count", times.size(), 8);
    check("run first pulse", (times.size() > 0) ? times[0] : -1, DIV + 1);
    bad = 0;
    for (int i = 1; i < times.size(); i++) if (times[i] - times[i-1] != int'(DIV)) bad++;
    check("run spacing errors", bad, 0);
    check("run run_mode", 32'(run_mode), 1);
    btn_n[1] = 1'b0;
    wait_for(1, 20, ok);
    check("stop pulse seen", 32'(ok), 1);
    btn_n[1] = 1'b1;
    npulse = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (cpu_en) npulse++; end
    check("stopped en pulses", npulse, 0);
    check("stopped run_mode", 32'(run_mode), 0);

    // ---- breakpoint
    do_reset();
    bp_en = 1'b1; bp_addr = 8'h03;
    press(3'b010, 6, 0);
    wait_for(4, 200, ok);
    check("bp halted", 32'(ok), 1);
    check("bp pc", pc_val, 32'h0C);
    check("bp step_count", 32'(step_count), 3);
    check("bp run_mode", 32'(run_mode), 0);
    btn_n[1] = 1'b0;
    wait_for(1, 20, ok);
    btn_n[1] = 1'b1;
    wait_for(3, 20, ok);
    pc_seen = pc_val;
    check("resume en seen", 32'(ok), 1);
    check("resume executes bp pc", pc_seen, 32'h0C);
    check("resume not halted", 32'(halted_bp), 0);
    check("resume run_mode", 32'(run_mode), 1);
    bp_addr = 8'h05;
    wait_for(4, 60, ok);
    check("bp2 halted", 32'(ok), 1);
    check("bp2 pc", pc_val, 32'h14);
    check("bp2 step_count", 32'(step_count), 5);
    e0 = en_total;
    press(3'b001, 6, 10);
    check("break step en", en_total - e0, 1);
    check("break step halted", 32'(halted_bp), 1);
    check("break step pc", pc_val, 32'h18);

    // ---- simultaneous step + run
    do_reset();
    btn_n = 3'b100;
    wait_for(0, 20, ok);
    check("collide step pulse", 32'(ok), 1);
    check("collide run pulse", 32'(btn_pulse[1]), 1);
    btn_n = 3'b111;
    tick();
    check("collide no step en", 32'(cpu_en), 0);
    check("collide run_mode", 32'(run_mode), 1);

    // ---- counter wrap, then clear coincident with cpu_en
    wait_for(5, 2400, ok);
    check("wrap reached max", 32'(ok), 1);
    wait_for(3, 12, ok);
    tick();
    check("wrap to zero", 32'(step_count), 0);
    wait_for(3, 12, ok);
    tick(); tick();
    btn_n[2] = 1'b0;
    repeat (6) tick();
    check("clear pulse aligned", 32'(btn_pulse[2]), 1);
    check("clear en aligned", 32'(cpu_en), 1);
    btn_n[2] = 1'b1;
    tick();
    check("clear wins", 32'(step_count), 0);
    check("clear keeps run", 32'(run_mode), 1);

    // ---- asynchronous reset mid-run, press held across reset
    wait_for(3, 12, ok);
    #2 RST = 1'b1; btn_n[0] = 1'b0;
    #1;
    check("async cpu_en", 32'(cpu_en), 0);
    check("async run_mode", 32'(run_mode), 0);
    check("async step_count", 32'(step_count), 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin tick(); if (btn_pulse[0] && lat == 0) lat = i; end
    btn_n[0] = 1'b1;
    check("rearm debounce latency", lat, 2 + DB);
    check("after reset idle", 32'(run_mode), 0);
    check("after reset step", 32'(step_count), 1);

    // ---- randomized
    random_test(4000);

    check("cpu_en back-to-back", en_back2back, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
